// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: opcode encodings, fetch FSM states,
// reset address default and the branch-offset helper.
package pc_fetch_unit_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_BEQ   = 6'b000100,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011,
      OP_HALT  = 6'b111111
   } opcode_t;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_HALT  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Word offset of a BEQ: sign-extend the 16-bit immediate and scale by 4.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats pc+4.
// All arithmetic wraps modulo 2^32.
module next_pc_calc
   import pc_fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] instr_low,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] next_pc
);

   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], instr_low, 2'b00};
      end else if (branch && zero) begin
         next_pc = pc_plus4 + branch_offset(instr_low[15:0]);
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: fetches the word at pc,
// holds it for the control unit, and advances pc on a pcupdate pulse.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter logic [5:0]  HALT_OPCODE = OP_HALT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        pcupdate,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [31:0] pc,
   output logic        instr_valid,
   output logic        halted,
   output logic        seq_err,
   output logic [1:0]  fsm_state
);

   // Memory handshake: imem_req is held high with a stable imem_addr from the
   // FETCH cycle until the cycle imem_valid is seen in WAIT; imem_valid is a
   // single-cycle strobe qualifying imem_rdata and is ignored outside WAIT.

   fetch_state_t state, state_nxt;
   logic [31:0]  next_pc;
   logic         fetching;

   next_pc_calc u_next_pc_calc (
      .pc        (pc),
      .instr_low (instr[25:0]),
      .jump      (jump),
      .branch    (branch),
      .zero      (zero),
      .next_pc   (next_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: state_nxt = S_WAIT;
         S_WAIT: begin
            if (imem_valid) begin
               state_nxt = (imem_rdata[31:26] == HALT_OPCODE) ? S_HALT : S_HOLD;
            end
         end
         S_HOLD: begin
            if (pcupdate) begin
               state_nxt = S_FETCH;
            end
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_FETCH;
      endcase
   end

   assign fetching = (state == S_FETCH) || (state == S_WAIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr       <= 32'h0;
         instr_valid <= 1'b0;
         seq_err     <= 1'b0;
      end else begin
         // A pcupdate while a fetch is in flight is a control-sequencing bug.
         if (pcupdate && fetching) begin
            seq_err <= 1'b1;
         end
         if ((state == S_WAIT) && imem_valid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
         end
         if ((state == S_HOLD) && pcupdate) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
         end
      end
   end

   assign imem_req  = fetching && !reset;
   assign imem_addr = pc;
   assign opcode    = instr[31:26];
   assign halted    = (state == S_HALT);
   assign fsm_state = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a table of fetch/update steps against a
// latency-programmable memory model, plus hand sequences for halt and reset.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcupdate;
   logic        jump;
   logic        branch;
   logic        zero;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_valid = 1'b0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc;
   logic        instr_valid;
   logic        halted;
   logic        seq_err;
   logic [1:0]  fsm_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int upd_cyc;
   int edges;

   // memory model state
   logic [31:0] mem [logic [31:0]];
   int          lat = 1;
   int          cnt = 0;
   logic        pending = 1'b0;
   logic [31:0] maddr = 32'h0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
      logic        j;
      logic        b;
      logic        z;
      logic [31:0] next;
      logic        poke;
   } vec_t;

   vec_t vecs [10];

   pc_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .pcupdate    (pcupdate),
      .jump        (jump),
      .branch      (branch),
      .zero        (zero),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .instr       (instr),
      .opcode      (opcode),
      .pc          (pc),
      .instr_valid (instr_valid),
      .halted      (halted),
      .seq_err     (seq_err),
      .fsm_state   (fsm_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: latch a request, return data 'lat' edges later as a one-cycle strobe.
   always @(posedge clk) begin
      if (reset) begin
         pending    <= 1'b0;
         imem_valid <= 1'b0;
         cnt        <= 0;
      end else begin
         imem_valid <= 1'b0;
         if (pending) begin
            if (cnt <= 1) begin
               imem_valid <= 1'b1;
               imem_rdata <= mem.exists(maddr) ? mem[maddr] : 32'h0;
               pending    <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end else if (imem_req && !imem_valid) begin
            pending <= 1'b1;
            cnt     <= lat;
            maddr   <= imem_addr;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive a one-cycle pcupdate; idle control lines are left high so that any
   // sampling outside the pulse edge would be visible.
   task automatic pulse_update(input logic j, input logic b, input logic z);
      @(negedge clk);
      pcupdate = 1'b1;
      jump     = j;
      branch   = b;
      zero     = z;
      @(posedge clk);
      #1;
      upd_cyc  = cyc;
      pcupdate = 1'b0;
      jump     = 1'b1;
      branch   = 1'b1;
      zero     = 1'b1;
   endtask

   task automatic wait_valid(output int n);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (instr_valid) break;
      end
      n = cyc - upd_cyc;
   endtask

   initial begin
      reset    = 1'b1;
      pcupdate = 1'b0;
      jump     = 1'b1;
      branch   = 1'b1;
      zero     = 1'b1;

      //          addr           word           j     b     z     next           poke
      vecs[0] = '{32'h0000_0000, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0};
      vecs[1] = '{32'h0000_0004, 32'h0800_0100, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 1'b0};
      vecs[2] = '{32'h0000_0008, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b0};
      vecs[3] = '{32'h0000_0004, 32'h0800_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b0};
      vecs[4] = '{32'h0000_0400, 32'h1000_FEFE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0};
      vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
      vecs[6] = '{32'h0000_0000, 32'h2008_0005, 1'b0, 1'b1, 1'b1, 32'h0000_0018, 1'b0};
      vecs[7] = '{32'h0000_0018, 32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC, 1'b0};
      vecs[8] = '{32'h0FFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 1'b0};
      vecs[9] = '{32'h1000_0000, 32'h0800_0010, 1'b1, 1'b1, 1'b1, 32'h1000_0040, 1'b0};
      foreach (vecs[i]) mem[vecs[i].addr] = vecs[i].word;
      mem[32'h1000_0040] = 32'hFC00_0000;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      check("rst_seq_err", {31'b0, seq_err}, 32'h0);
      check("rst_req_forced", {31'b0, imem_req}, 32'h0);
      check("rst_state", {30'b0, fsm_state}, 32'h0);
      @(negedge clk);
      reset   = 1'b0;
      upd_cyc = cyc;
      #1;
      check("post_rst_req", {31'b0, imem_req}, 32'h1);
      check("post_rst_addr", imem_addr, 32'h0);

      // table-driven fetch / update steps
      for (int i = 0; i < 10; i++) begin
         wait_valid(edges);
         check($sformatf("v%0d_latency", i), edges, 32'd3);
         check($sformatf("v%0d_instr", i), instr, vecs[i].word);
         check($sformatf("v%0d_opcode", i), {26'b0, opcode}, {26'b0, vecs[i].word[31:26]});
         check($sformatf("v%0d_pc", i), pc, vecs[i].addr);
         check($sformatf("v%0d_hold_req", i), {31'b0, imem_req}, 32'h0);
         pulse_update(vecs[i].j, vecs[i].b, vecs[i].z);
         check($sformatf("v%0d_next_pc", i), pc, vecs[i].next);
         check($sformatf("v%0d_valid_clr", i), {31'b0, instr_valid}, 32'h0);
         check($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'h1);
         check($sformatf("v%0d_addr", i), imem_addr, vecs[i].next);
         if (vecs[i].poke) begin
            check("poke_seq_err_before", {31'b0, seq_err}, 32'h0);
            @(posedge clk);
            @(negedge clk);
            check("poke_in_wait", {30'b0, fsm_state}, 32'd1);
            pcupdate = 1'b1;
            @(posedge clk);
            #1;
            pcupdate = 1'b0;
            check("poke_seq_err", {31'b0, seq_err}, 32'h1);
            check("poke_pc_kept", pc, vecs[i].next);
         end
      end

      // halt fetch
      wait_valid(edges);
      check("halt_latency", edges, 32'd3);
      check("halt_instr", instr, 32'hFC00_0000);
      check("halt_opcode", {26'b0, opcode}, 32'h3F);
      check("halt_flag", {31'b0, halted}, 32'h1);
      check("halt_req", {31'b0, imem_req}, 32'h0);
      pulse_update(1'b1, 1'b1, 1'b1);
      check("halt_pc_frozen", pc, 32'h1000_0040);
      check("halt_instr_frozen", instr, 32'hFC00_0000);
      check("halt_seq_err_kept", {31'b0, seq_err}, 32'h1);
      check("halt_still", {31'b0, halted}, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      check("halt_req_idle", {31'b0, imem_req}, 32'h0);

      // reset mid-WAIT on a 3-cycle memory, coinciding with a pcupdate
      @(negedge clk);
      reset = 1'b1;
      lat   = 3;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_wait_state", {30'b0, fsm_state}, 32'd1);
      reset    = 1'b1;
      pcupdate = 1'b1;
      #1;
      check("mid_wait_req_forced", {31'b0, imem_req}, 32'h0);
      @(posedge clk);
      #1;
      pcupdate = 1'b0;
      check("rst2_pc", pc, 32'h0);
      check("rst2_seq_err", {31'b0, seq_err}, 32'h0);
      check("rst2_halted", {31'b0, halted}, 32'h0);
      check("rst2_instr", instr, 32'h0);
      check("rst2_state", {30'b0, fsm_state}, 32'h0);
      @(negedge clk);
      reset   = 1'b0;
      upd_cyc = cyc;
      #1;
      check("rst2_req", {31'b0, imem_req}, 32'h1);
      check("rst2_addr", imem_addr, 32'h0);
      wait_valid(edges);
      check("lat3_latency", edges, 32'd5);
      check("lat3_instr", instr, 32'h2008_0005);
      check("lat3_seq_err", {31'b0, seq_err}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
